// File: rtl/hold_frame_rx_if.sv
// rtl/hold_frame_rx_if.sv - frame line inputs and decoder status outputs of hold_frame_rx
interface hold_frame_rx_if #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
);
  logic             g_in;
  logic             f_in;
  logic             busy;
  logic             frame_ok;
  logic             err;
  logic [2:0]       err_code;
  logic [LEN_W-1:0] len_last;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  // Transmitter / monitor side: drives the frame lines, observes status.
  modport master (
    output g_in, f_in,
    input  busy, frame_ok, err, err_code, len_last, frame_cnt, err_cnt
  );

  // Receiver side: samples the frame lines, reports status.
  modport slave (
    input  g_in, f_in,
    output busy, frame_ok, err, err_code, len_last, frame_cnt, err_cnt
  );
endinterface

// File: rtl/hold_frame_rx.sv
// rtl/hold_frame_rx.sv - receive-side checker/decoder for the hold-style g/f frame pattern
module hold_frame_rx #(
  parameter int EXP_LEN = 6,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  hold_frame_rx_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    TAIL   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [LEN_W-1:0] EXP_L   = LEN_W'(EXP_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic             g_d, f_d;
  // Cleared by reset; the first sampled cycle after release has no valid
  // history in g_d/f_d, so edges are not trusted until it has been seen.
  // This is what lets a frame in progress at release fall into DRAIN.
  logic             armed;
  logic [LEN_W-1:0] len, len_nxt, len_inc;
  logic             ok_nxt, err_nxt, last_upd;
  logic [2:0]       code_nxt;
  logic             rise, tog;

  logic             frame_ok_q, err_q;
  logic [2:0]       err_code_q;
  logic [LEN_W-1:0] len_last_q;
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

  assign rise    = armed & bus.g_in & ~g_d;
  assign tog     = armed & (bus.f_in ^ f_d);
  assign len_inc = (len == LEN_MAX) ? len : len + LEN_W'(1);

  // Next-state, length tracking and pulse decode for the frame FSM.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    ok_nxt    = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = 3'b000;
    last_upd  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          len_nxt   = LEN_W'(1);
          state_nxt = tog ? TAIL : ACTIVE;
        end else if (!bus.g_in && tog) begin
          err_nxt  = 1'b1;
          code_nxt = 3'b010;
        end else if (bus.g_in) begin
          state_nxt = DRAIN;
        end
      end
      ACTIVE: begin
        if (bus.g_in) begin
          len_nxt = len_inc;
          if (tog) state_nxt = TAIL;
        end else begin
          err_nxt   = 1'b1;
          code_nxt  = {1'b0, tog, 1'b1};
          state_nxt = IDLE;
        end
      end
      TAIL: begin
        // A second toggle or a wrong length/tail turns the frame into an error.
        code_nxt  = {(bus.g_in || (len != EXP_L)), tog, 1'b0};
        ok_nxt    = (code_nxt == 3'b000);
        err_nxt   = !ok_nxt;
        last_upd  = ok_nxt || code_nxt[2];
        state_nxt = bus.g_in ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!bus.g_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Input history, FSM state and registered status; clr overrides the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_d         <= 1'b0;
      f_d         <= 1'b0;
      armed       <= 1'b0;
      state       <= IDLE;
      len         <= '0;
      frame_ok_q  <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 3'b000;
      len_last_q  <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      g_d   <= bus.g_in;
      f_d   <= bus.f_in;
      armed <= 1'b1;
      if (clr) begin
        state       <= IDLE;
        len         <= '0;
        frame_ok_q  <= 1'b0;
        err_q       <= 1'b0;
        err_code_q  <= 3'b000;
        len_last_q  <= '0;
        frame_cnt_q <= '0;
        err_cnt_q   <= '0;
      end else begin
        state      <= state_nxt;
        len        <= len_nxt;
        frame_ok_q <= ok_nxt;
        err_q      <= err_nxt;
        err_code_q <= err_nxt ? code_nxt : 3'b000;
        if (last_upd) len_last_q <= len;
        if (ok_nxt) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        if (err_nxt && (err_cnt_q != CNT_MAX)) err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.frame_ok  = frame_ok_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.len_last  = len_last_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hold_frame_rx.sv
// tb/tb_hold_frame_rx.sv - self-checking bench for hold_frame_rx
module tb_hold_frame_rx;

  localparam int EXP_LEN = 6;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  hold_frame_rx_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  hold_frame_rx #(.EXP_LEN(EXP_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Frame-level reference: position within the current frame, position of
  // its marker, and whether the rest of a high run is being discarded.
  int   m_pos, m_mark, m_skip, m_armed, m_pg, m_pf;
  int   m_fc, m_ec, m_ll;
  int   x_ok, x_err, x_code;

  int   ok_seen, err_seen, last_code;
  logic cur_f;

  typedef struct {
    logic       g;
    logic       f;
    logic       ok;
    logic       er;
    logic [2:0] code;
    logic       busy;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_mark = 0; m_skip = 0; m_armed = 0; m_pg = 0; m_pf = 0;
    m_fc = 0; m_ec = 0; m_ll = 0;
    x_ok = 0; x_err = 0; x_code = 0;
  endtask

  task automatic model_step(input logic g, input logic f, input logic c);
    int tog, rise;
    tog  = (m_armed != 0) && (int'(f) != m_pf);
    rise = (m_armed != 0) && g && (m_pg == 0);
    x_ok = 0; x_err = 0; x_code = 0;
    if (c) begin
      m_fc = 0; m_ec = 0; m_ll = 0;
      m_pos = 0; m_mark = 0; m_skip = 0;
    end else if (m_skip != 0) begin
      if (!g) m_skip = 0;
    end else if (m_pos == 0) begin
      if (rise) begin
        m_pos  = 1;
        m_mark = tog;
      end else if (!g && tog) begin
        x_err = 1; x_code = 2;
      end else if (g) begin
        m_skip = 1;
      end
    end else if (m_mark == 0) begin
      if (g) begin
        m_pos  = (m_pos < LEN_MAX) ? m_pos + 1 : LEN_MAX;
        m_mark = tog;
      end else begin
        x_err  = 1;
        x_code = 1 + (tog ? 2 : 0);
        m_pos  = 0;
      end
    end else begin
      x_code = tog ? 2 : 0;
      if (g || m_pos != EXP_LEN) x_code += 4;
      if (x_code == 0) x_ok = 1; else x_err = 1;
      if (x_ok != 0 || x_code >= 4) m_ll = m_pos;
      if (g) m_skip = 1;
      m_pos = 0; m_mark = 0;
    end
    if (x_ok != 0) m_fc = (m_fc + 1) % 256;
    if (x_err != 0 && m_ec < 255) m_ec++;
    m_pg = g; m_pf = f; m_armed = 1;
  endtask

  task automatic observe();
    if (bus.frame_ok) ok_seen++;
    if (bus.err) begin
      err_seen++;
      last_code = int'(bus.err_code);
    end
  endtask

  task automatic compare_all();
    chk("frame_ok", 32'(bus.frame_ok), 32'(x_ok));
    chk("err", 32'(bus.err), 32'(x_err));
    if (x_err != 0) chk("err_code", 32'(bus.err_code), 32'(x_code));
    chk("busy", 32'(bus.busy), 32'((m_pos != 0) || (m_skip != 0)));
    chk("len_last", 32'(bus.len_last), 32'(m_ll));
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_fc));
    chk("err_cnt", 32'(bus.err_cnt), 32'(m_ec));
    observe();
  endtask

  task automatic cyc(input logic g, input logic f, input logic c);
    bus.g_in = g; bus.f_in = f; clr = c; cur_f = f;
    @(posedge clk);
    model_step(g, f, c);
    #1;
    compare_all();
  endtask

  // n high cycles, marker toggle in high cycle m (0: none), then one low cycle.
  task automatic send_frame(input int n, input int m);
    for (int i = 1; i <= n; i++) begin
      cyc(1'b1, (i == m) ? ~cur_f : cur_f, 1'b0);
    end
    cyc(1'b0, cur_f, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not end within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{g:1'b0, f:1'b0, ok:1'b0, er:1'b0, code:3'b000, busy:1'b0};
    for (int i = 1; i <= 5; i++)
      tbl[i] = '{g:1'b1, f:1'b0, ok:1'b0, er:1'b0, code:3'b000, busy:1'b1};
    tbl[6]  = '{g:1'b1, f:1'b1, ok:1'b0, er:1'b0, code:3'b000, busy:1'b1};
    tbl[7]  = '{g:1'b0, f:1'b1, ok:1'b1, er:1'b0, code:3'b000, busy:1'b0};
    tbl[8]  = '{g:1'b0, f:1'b1, ok:1'b0, er:1'b0, code:3'b000, busy:1'b0};
    tbl[9]  = '{g:1'b0, f:1'b0, ok:1'b0, er:1'b1, code:3'b010, busy:1'b0};
    tbl[10] = '{g:1'b0, f:1'b0, ok:1'b0, er:1'b0, code:3'b000, busy:1'b0};

    ok_seen = 0; err_seen = 0; last_code = 0; cur_f = 1'b0;
    rst_n = 1'b0; clr = 1'b0; bus.g_in = 1'b0; bus.f_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst frame_ok", 32'(bus.frame_ok), 0);
    chk("rst err", 32'(bus.err), 0);
    chk("rst err_code", 32'(bus.err_code), 0);
    chk("rst len_last", 32'(bus.len_last), 0);
    chk("rst frame_cnt", 32'(bus.frame_cnt), 0);
    chk("rst err_cnt", 32'(bus.err_cnt), 0);
    rst_n = 1'b1;

    // Nominal frame and a stray toggle straight out of reset.
    for (int i = 0; i < 11; i++) begin
      bus.g_in = tbl[i].g; bus.f_in = tbl[i].f; cur_f = tbl[i].f;
      @(posedge clk);
      model_step(tbl[i].g, tbl[i].f, 1'b0);
      #1;
      chk($sformatf("tbl%0d frame_ok", i), 32'(bus.frame_ok), 32'(tbl[i].ok));
      chk($sformatf("tbl%0d err", i), 32'(bus.err), 32'(tbl[i].er));
      if (tbl[i].er) chk($sformatf("tbl%0d err_code", i), 32'(bus.err_code), 32'(tbl[i].code));
      chk($sformatf("tbl%0d busy", i), 32'(bus.busy), 32'(tbl[i].busy));
    end
    chk("nominal len_last", 32'(bus.len_last), 6);
    chk("nominal frame_cnt", 32'(bus.frame_cnt), 1);
    chk("nominal err_cnt", 32'(bus.err_cnt), 1);

    // Back-to-back frames with a single low cycle between them.
    ok_seen = 0;
    for (int i = 0; i < 3; i++) send_frame(6, 6);
    chk("b2b ok pulses", 32'(ok_seen), 3);
    chk("b2b frame_cnt", 32'(bus.frame_cnt), 4);

    // Short frame: marker on the 5th cycle.
    last_code = 0;
    send_frame(5, 5); cyc(1'b0, cur_f, 1'b0);
    chk("short code", 32'(last_code), 4);
    chk("short len_last", 32'(bus.len_last), 5);

    // Long frame: marker on 6th, g stays high; drained, then a good frame.
    last_code = 0; ok_seen = 0;
    send_frame(8, 6);
    chk("long code", 32'(last_code), 4);
    send_frame(6, 6);
    chk("after long ok", 32'(ok_seen), 1);

    // Missing marker.
    last_code = 0; err_seen = 0;
    send_frame(6, 0); cyc(1'b0, cur_f, 1'b0);
    chk("missing code", 32'(last_code), 1);
    chk("missing err pulses", 32'(err_seen), 1);
    chk("missing frame_cnt", 32'(bus.frame_cnt), 5);

    // Stray toggle in idle followed by a good frame.
    last_code = 0; ok_seen = 0;
    cyc(1'b0, ~cur_f, 1'b0); cyc(1'b0, cur_f, 1'b0);
    chk("stray code", 32'(last_code), 2);
    send_frame(6, 6);
    chk("after stray ok", 32'(ok_seen), 1);

    // One-cycle frame and length-counter saturation.
    send_frame(1, 1);
    chk("len1 len_last", 32'(bus.len_last), 1);
    send_frame(18, 17);
    chk("sat len_last", 32'(bus.len_last), LEN_MAX);

    // Asynchronous reset in the 3rd high cycle, released while g is high.
    cyc(1'b0, cur_f, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, cur_f, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("async busy", 32'(bus.busy), 0);
    chk("async frame_cnt", 32'(bus.frame_cnt), 0);
    chk("async err_cnt", 32'(bus.err_cnt), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ok_seen = 0; err_seen = 0;
    cyc(1'b1, cur_f, 1'b0); cyc(1'b1, cur_f, 1'b0); cyc(1'b1, ~cur_f, 1'b0);
    cyc(1'b0, cur_f, 1'b0); cyc(1'b0, cur_f, 1'b0);
    chk("post-reset pulses", 32'(ok_seen + err_seen), 0);
    for (int i = 0; i < 3; i++) send_frame(6, 6);
    chk("post-reset ok", 32'(ok_seen), 3);
    chk("pre-clr frame_cnt", 32'(bus.frame_cnt), 3);

    // Synchronous clear.
    cyc(1'b0, ~cur_f, 1'b0);
    cyc(1'b0, cur_f, 1'b1);
    chk("clr frame_cnt", 32'(bus.frame_cnt), 0);
    chk("clr err_cnt", 32'(bus.err_cnt), 0);
    chk("clr len_last", 32'(bus.len_last), 0);

    // Randomised traffic against the reference.
    for (int k = 0; k < 400; k++) begin
      int r, n;
      r = int'($urandom_range(0, 11));
      if (r < 8) begin
        n = int'($urandom_range(1, 9));
        send_frame(n, (r < 4) ? n : int'($urandom_range(0, n)));
        repeat ($urandom_range(0, 1)) cyc(1'b0, cur_f, 1'b0);
      end else if (r < 10) begin
        repeat ($urandom_range(1, 6))
          cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end else if (r == 10) begin
        cyc(1'($urandom_range(0, 1)), cur_f, 1'b1);
      end else begin
        cyc(1'b0, cur_f, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/hold_frame_rx.md
Name: hold_frame_rx

Overview:
- Receive-side checker and decoder for the hold-style frame pattern.
- A transmitter drives a level `g` (frame active) and a toggle marker `f`. A well-formed frame is:
  - `g` high for EXP_LEN consecutive cycles;
  - exactly one `f` toggle, occurring in the last `g`-high cycle;
  - `g` low on the following cycle.
- This block samples `g`/`f` in the same clock domain, measures each frame, and reports good frames, protocol errors and counts to a status/monitor layer.

Parameters:
- EXP_LEN, 6, required number of `g_in`-high cycles per frame, counting the marker cycle; 1..2^LEN_W-2.
- LEN_W, 4, width of the frame length counter and `len_last`.
- CNT_W, 8, width of `frame_cnt` and `err_cnt`.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- clr  input  1  synchronous clear: counters to 0, FSM to IDLE, sampled history kept
- g_in  input  1  frame-active level from transmitter, synchronous to clk
- f_in  input  1  toggle marker from transmitter, synchronous to clk
- busy  output  1  high while FSM is not IDLE
- frame_ok  output  1  one-cycle pulse: well-formed frame completed
- err  output  1  one-cycle pulse: protocol error detected
- err_code  output  3  valid with `err`: bit0 missing marker, bit1 stray toggle, bit2 length/tail error
- len_last  output  LEN_W  measured length of most recent frame, updated on `frame_ok` or bit2 error
- frame_cnt  output  CNT_W  count of good frames, wraps
- err_cnt  output  CNT_W  count of `err` pulses, saturates at all-ones

Behaviour:
- **Reset values:** all outputs 0. Internal `g_d`=0, `f_d`=0, `len`=0, state=IDLE.
- **Edge detection:**
  - `g_d`/`f_d` register `g_in`/`f_in` every cycle.
  - rise = `g_in & ~g_d`.
  - tog = `f_in ^ f_d`.
- **Output timing:** all outputs are registered and update on the edge that samples the triggering input values, so they are visible one cycle after the inputs.
- **Pulses:** `frame_ok` and `err` are single-cycle and never both high. Counters update on the same edge as their pulse.
- **State IDLE:**
  - rise & ~tog: `len`<=1, go to ACTIVE.
  - rise & tog: `len`<=1, go to TAIL (one-cycle frame).
  - ~g_in & tog: `err`, code 010, stay IDLE.
  - `g_in` high without rise (e.g. high at reset release): go to DRAIN, no error.
- **State ACTIVE:**
  - g_in & ~tog: `len`<=sat(`len`+1); `len` saturates at 2^LEN_W-1.
  - g_in & tog: `len`<=sat(`len`+1), go to TAIL.
  - ~g_in: `err`, code 001, `len_last` unchanged, go to IDLE. A tog in that same cycle also sets bit1 (code 011).
- **State TAIL:**
  - ~g_in & `len`==EXP_LEN: `frame_ok`, `len_last`<=`len`, `frame_cnt`+1, go to IDLE.
  - ~g_in & `len`!=EXP_LEN: `err`, code 100, `len_last`<=`len`, go to IDLE.
  - g_in: `err`, code 100, `len_last`<=`len`, go to DRAIN.
  - A tog in the TAIL cycle additionally sets bit1.
- **State DRAIN:** wait for ~g_in, then go to IDLE. Toggles are ignored, no pulses.
- **Back-to-back frames:** minimum gap is one `g_in`-low cycle; the rise is detected from IDLE the cycle after TAIL. A rise cannot be missed: TAIL/ACTIVE exit to IDLE only on a `g_in`-low cycle.
- **clr:**
  - Has priority over FSM actions that cycle.
  - Suppresses pulses.
  - Zeroes `frame_cnt`, `err_cnt`, `len_last`.
  - Sets state to IDLE.
- **Async reset mid-frame:** immediate return to reset values. A frame in progress at release is absorbed via DRAIN without error.

Test Plan:
- **Nominal frame:** from reset, drive `g_in` high 6 cycles, toggle `f_in` 0->1 in the 6th high cycle, then `g_in` low. Expect `frame_ok`=1 for exactly one cycle, 2 cycles after the 6th high cycle; `len_last`=6; `frame_cnt`=1; `err`=0.
- **Back-to-back:** 3 nominal frames separated by 1 low cycle, with `f` alternating 1,0,1. Expect 3 `frame_ok` pulses and `frame_cnt`=3.
- **Length errors:**
  - 5 high cycles with marker on 5th: `err` with code 100, `len_last`=5.
  - 8 high cycles with marker on 6th: code 100, FSM passes through DRAIN, next nominal frame OK.
- **Missing marker:** `g_in` high 6 cycles, no toggle, then low. Expect code 001, `err_cnt`=1, `frame_cnt` unchanged.
- **Stray toggle:** toggle `f_in` while `g_in`=0 in IDLE. Expect code 010, then a following nominal frame gives `frame_ok`.
- **Reset/clear:**
  - Assert `rst_n` low mid-frame (cycle 3), release while `g_in` still high. Expect no pulses until the next full frame, which passes.
  - Assert `clr` with `frame_cnt`=3: counters return to 0 on the next cycle.
